// File: rtl/proj1_if.sv
// Operand/opcode and registered result/flag bundle for the proj1 ALU.
// Member names match the ALU's external pin names.
interface proj1_if #(
    parameter int unsigned WIDTH = 10
);
    logic signed [WIDTH-1:0] i_arg0;
    logic signed [WIDTH-1:0] i_arg1;
    logic [2:0]              i_oper;
    logic signed [WIDTH-1:0] o_result;
    logic [3:0]              o_flag;

    modport master (
        output i_arg0,
        output i_arg1,
        output i_oper,
        input  o_result,
        input  o_flag
    );

    modport slave (
        input  i_arg0,
        input  i_arg1,
        input  i_oper,
        output o_result,
        output o_flag
    );
endinterface

// File: rtl/proj1.sv
// Signed two's-complement ALU with eight operations and one cycle of latency.
// Flags are packed as {V, C, N, Z}.
module proj1 #(
    parameter int unsigned WIDTH = 10
) (
    input logic  i_clk,
    input logic  i_rst_n,
    proj1_if.slave bus
);

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpMax  = 3'd2,
        OpMin  = 3'd3,
        OpAnd  = 3'd4,
        OpOrr  = 3'd5,
        OpXor  = 3'd6,
        OpXnor = 3'd7
    } op_e;

    logic [WIDTH-1:0] arg_a;
    logic [WIDTH-1:0] arg_b;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             a_gt_b;
    op_e              op;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d;
    logic             ovf_d;
    logic [3:0]       flag_d, flag_q;

    assign arg_a    = bus.i_arg0;
    assign arg_b    = bus.i_arg1;
    assign op       = op_e'(bus.i_oper);
    assign sum_ext  = {1'b0, arg_a} + {1'b0, arg_b};
    // Bit WIDTH of the zero-extended difference is the unsigned borrow.
    assign diff_ext = {1'b0, arg_a} - {1'b0, arg_b};
    assign a_gt_b   = $signed(arg_a) > $signed(arg_b);

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        unique case (op)
            OpAdd: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                ovf_d    = (arg_a[WIDTH-1] == arg_b[WIDTH-1]) &&
                           (result_d[WIDTH-1] != arg_a[WIDTH-1]);
            end
            OpSub: begin
                result_d = diff_ext[WIDTH-1:0];
                carry_d  = diff_ext[WIDTH];
                ovf_d    = (arg_a[WIDTH-1] != arg_b[WIDTH-1]) &&
                           (result_d[WIDTH-1] != arg_a[WIDTH-1]);
            end
            OpMax:  result_d = a_gt_b ? arg_a : arg_b;
            // Ties resolve to A for both MAX and MIN.
            OpMin:  result_d = ($signed(arg_a) <= $signed(arg_b)) ? arg_a : arg_b;
            OpAnd:  result_d = arg_a & arg_b;
            OpOrr:  result_d = arg_a | arg_b;
            OpXor:  result_d = arg_a ^ arg_b;
            OpXnor: result_d = ~(arg_a ^ arg_b);
        endcase
        flag_d = {ovf_d, carry_d, result_d[WIDTH-1], (result_d == '0)};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_flag   = flag_q;

endmodule

// File: tb/tb_proj1.sv
// Directed-vector bench for proj1: the driver queues expected results, the
// monitor pops and compares one cycle after each captured vector.
module tb_proj1;

    localparam int unsigned WIDTH = 10;

    typedef struct {
        logic signed [WIDTH-1:0] a;
        logic signed [WIDTH-1:0] b;
        logic [2:0]              op;
        logic signed [WIDTH-1:0] r;
        logic [3:0]              f;
    } vec_t;

    typedef struct {
        logic signed [WIDTH-1:0] r;
        logic [3:0]              f;
        int                      id;
    } exp_t;

    logic clk;
    logic rst_n;
    logic drv_valid;
    int   n_cmp;
    int   n_err;
    int   vec_id;
    exp_t sb[$];
    vec_t vecs[$];

    proj1_if #(.WIDTH(WIDTH)) bus ();

    proj1 #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a, input int b, input int op, input int r,
                                input logic [3:0] f);
        vec_t v;
        v.a  = WIDTH'(a);
        v.b  = WIDTH'(b);
        v.op = 3'(op);
        v.r  = WIDTH'(r);
        v.f  = f;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.i_arg0 = v.a;
        bus.i_arg1 = v.b;
        bus.i_oper = v.op;
        e.r  = v.r;
        e.f  = v.f;
        e.id = vec_id;
        vec_id++;
        sb.push_back(e);
        drv_valid = 1'b1;
    endtask

    // Monitor: every edge that captured a driven vector yields one output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && drv_valid) begin
                #1;
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result[%0d]", e.id), int'(bus.o_result), int'(e.r));
                    check($sformatf("flag[%0d]", e.id), int'(bus.o_flag), int'(e.f));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        vec_id    = 0;
        drv_valid = 1'b0;
        rst_n     = 1'b0;
        bus.i_arg0 = 10'sd64;
        bus.i_arg1 = 10'sd16;
        bus.i_oper = 3'd0;

        // A=64, B=16 across all opcodes.
        vecs.push_back(mk(64, 16, 0, 80, 4'b0000));
        vecs.push_back(mk(64, 16, 1, 48, 4'b0000));
        vecs.push_back(mk(64, 16, 2, 64, 4'b0000));
        vecs.push_back(mk(64, 16, 3, 16, 4'b0000));
        vecs.push_back(mk(64, 16, 4, 0, 4'b0001));
        vecs.push_back(mk(64, 16, 5, 80, 4'b0000));
        vecs.push_back(mk(64, 16, 6, 80, 4'b0000));
        vecs.push_back(mk(64, 16, 7, -81, 4'b0010));
        // Add / sub overflow and borrow.
        vecs.push_back(mk(511, 511, 0, -2, 4'b1010));
        vecs.push_back(mk(-511, -511, 0, 2, 4'b1100));
        vecs.push_back(mk(511, -511, 1, -2, 4'b1110));
        vecs.push_back(mk(-511, 511, 1, 2, 4'b1000));
        vecs.push_back(mk(200, -100, 1, 300, 4'b0100));
        vecs.push_back(mk(-200, 100, 1, -300, 4'b0010));
        vecs.push_back(mk(200, 300, 1, -100, 4'b0110));
        vecs.push_back(mk(-200, -300, 1, 100, 4'b0000));
        // Boundaries.
        vecs.push_back(mk(-1, 1, 2, 1, 4'b0000));
        vecs.push_back(mk(-512, 511, 3, -512, 4'b0010));
        vecs.push_back(mk(123, 123, 6, 0, 4'b0001));
        vecs.push_back(mk(-512, -1, 2, -1, 4'b0010));
        vecs.push_back(mk(-5, 3, 3, -5, 4'b0010));
        vecs.push_back(mk(-1, 1, 0, 0, 4'b0101));
        vecs.push_back(mk(5, 5, 1, 0, 4'b0001));
        vecs.push_back(mk(-512, 1, 1, 511, 4'b1000));

        repeat (2) @(posedge clk);
        #1;
        check("reset_result", int'(bus.o_result), 0);
        check("reset_flag", int'(bus.o_flag), 0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) drive(vecs[i]);
        @(negedge clk);
        drv_valid = 1'b0;

        // Asynchronous reset between edges clears a just-captured result.
        drive(mk(511, 511, 0, -2, 4'b1010));
        @(negedge clk);
        drv_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_result", int'(bus.o_result), 0);
        check("async_reset_flag", int'(bus.o_flag), 0);
        @(posedge clk);
        #1;
        check("held_reset_result", int'(bus.o_result), 0);
        check("held_reset_flag", int'(bus.o_flag), 0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(64, 16, 0, 80, 4'b0000));
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proj1.md
Name: proj1

Overview:
- 10-bit signed two's-complement ALU with eight operations selected by a 3-bit opcode.
- Produces a 10-bit result and a 4-bit status flag vector.
- Inputs are sampled and outputs registered on each rising clock edge, giving one cycle of latency.
- Used as a standalone arithmetic/logic stage; no handshake, so a new operation may be accepted every cycle.

Parameters:
- WIDTH, 10, operand/result width in bits; all behaviour below is stated for WIDTH=10.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_arg0  input  10  operand A, signed two's complement.
- i_arg1  input  10  operand B, signed two's complement.
- i_oper  input  3  opcode: 0 ADD, 1 SUB, 2 MAX, 3 MIN, 4 AND, 5 ORR, 6 XOR, 7 XNOR.
- o_result  output  10  registered result, signed.
- o_flag  output  4  registered flags: [0] Z zero, [1] N negative, [2] C carry/borrow, [3] V signed overflow.

Behaviour:
- Reset:
  - While i_rst_n=0, o_result=0 and o_flag=0 immediately (asynchronous).
  - Release is synchronous to the next rising edge; the first capture happens on the first rising edge with i_rst_n=1.
  - Reset asserted mid-operation discards any in-flight result.
- Latency and throughput:
  - On each rising edge, o_result/o_flag load the function of i_arg0/i_arg1/i_oper as sampled at that edge. Latency is 1 cycle.
  - Outputs hold between edges. Throughput is one operation per cycle.
- ADD:
  - result = (A+B) mod 2^10, wrapping.
  - C = carry out of bit 9 (unsigned sum ≥ 1024).
  - V = 1 when A and B have the same sign and the result sign differs.
- SUB:
  - result = (A−B) mod 2^10, wrapping.
  - C = borrow (unsigned A < unsigned B).
  - V = 1 when A and B have different signs and the result sign differs from A.
- MAX / MIN:
  - Signed comparison; result = larger/smaller of A and B. For equal operands, result = A.
  - C=0, V=0.
- AND / ORR / XOR / XNOR:
  - Bitwise over all 10 bits.
  - C=0, V=0.
- Z and N, for all operations:
  - Z = (result == 0).
  - N = result[9].
- Undefined opcode values do not exist (3-bit opcode fully decoded). No saturation anywhere; overflow is reported only via V.
- X on inputs is not required to be handled; the reset value is always defined.

Test Plan:
1. Reset, then release with i_rst_n: assert reset asynchronously between edges -> o_result=0 and o_flag=4'b0000 immediately. After release, the first edge with A=64, B=16, ADD -> o_result=80, flags 0000.
2. A=64 (0001000000), B=16 (0000010000), one op per cycle, results one cycle later:
   - ADD->80; SUB->48; MAX->64; MIN->16.
   - AND->0 with Z=1 (flags 0001).
   - ORR->80; XOR->80.
   - XNOR->−81 (1110101111), N=1 (flags 0010).
3. Add overflow:
   - 511+511 -> −2 (1111111110), V=1, N=1, C=0 (flags 1010).
   - −511+−511 -> 2, V=1, C=1, N=0 (flags 1100).
4. Sub overflow:
   - 511−(−511) -> −2, V=1, N=1, C=1 (flags 1110).
   - −511−511 -> 2, V=1, C=0 (flags 1000).
5. Sub without overflow:
   - 200−(−100) -> 300, flags 0100 (borrow: 200 < 924 unsigned).
   - −200−100 -> −300, N=1, C=0, flags 0010.
   - 200−300 -> −100, N=1, C=1, flags 0110.
   - −200−(−300) -> 100, flags 0000.
6. Boundaries:
   - MAX(−1,1)->1; MIN(−512,511)->−512, N=1.
   - XOR(A,A)->0, Z=1.
   - Back-to-back ops each cycle produce each result exactly one cycle after its inputs.
